// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: deserializer-side bundle of the UART RX controller.
//   sampled_bit  majority-voted value of the current bit
//   deser_en     one-cycle shift strobe per data bit
//   data_valid   one-cycle pulse when a frame is accepted
//   par_err      parity mismatch on the last frame (level)
//   stp_err      stop bit sampled low on the last frame (level)
// master: driven by the controller; slave: seen by the deserializer.
interface uart_rx_ctrl_if;
   logic sampled_bit, deser_en, data_valid, par_err, stp_err;
   modport master(output sampled_bit, deser_en, data_valid, par_err, stp_err);
   modport slave(input sampled_bit, deser_en, data_valid, par_err, stp_err);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receive controller feeding an 8-bit deserializer.
//   clk       oversampling clock (prescale x baud)
//   rst_n     asynchronous active-low reset
//   rx_in     serial line, idle high, pre-synchronised
//   prescale  clk cycles per bit (8/16/32, below 8 acts as 8), latched at frame start
//   par_en    parity bit follows the data, latched at frame start
//   par_typ   0 even / 1 odd, latched at frame start
//   deser     master side of uart_rx_ctrl_if (sampled_bit, deser_en, data_valid, par_err, stp_err)
module uart_rx_ctrl #(parameter int PRESCALE_W = 6) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  par_en,
   input  logic                  par_typ,
   uart_rx_ctrl_if.master        deser
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state;
   logic [PRESCALE_W-1:0] p, m, edge_cnt;
   logic [2:0] bit_cnt;
   logic par_en_l, par_typ_l, s_lo, s_mid, par_acc, vote, tick, bit_end;
   assign m = p >> 1;
   // third sample is taken straight from the line so the vote lands one cycle earlier
   assign vote = (s_lo & s_mid) | (s_lo & rx_in) | (s_mid & rx_in);
   // decision edge: registered results become visible while edge_cnt == M+2
   assign tick = edge_cnt == m + PRESCALE_W'(1);
   assign bit_end = edge_cnt == p - PRESCALE_W'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         p <= '0;
         edge_cnt <= '0;
         bit_cnt <= '0;
         par_en_l <= 1'b0;
         par_typ_l <= 1'b0;
         s_lo <= 1'b0;
         s_mid <= 1'b0;
         par_acc <= 1'b0;
         deser.sampled_bit <= 1'b0;
         deser.deser_en <= 1'b0;
         deser.data_valid <= 1'b0;
         deser.par_err <= 1'b0;
         deser.stp_err <= 1'b0;
      end else begin
         deser.deser_en <= 1'b0;
         deser.data_valid <= 1'b0;
         if (state != IDLE) begin
            edge_cnt <= bit_end ? '0 : edge_cnt + PRESCALE_W'(1);
            if (edge_cnt == m - PRESCALE_W'(1)) s_lo <= rx_in;
            if (edge_cnt == m) s_mid <= rx_in;
            if (tick) deser.sampled_bit <= vote;
         end
         case (state)
            IDLE:
               if (!rx_in) begin
                  // the detecting cycle counts as edge 0
                  state <= START;
                  edge_cnt <= PRESCALE_W'(1);
                  p <= prescale < PRESCALE_W'(8) ? PRESCALE_W'(8) : prescale;
                  par_en_l <= par_en;
                  par_typ_l <= par_typ;
                  par_acc <= 1'b0;
                  deser.par_err <= 1'b0;
                  deser.stp_err <= 1'b0;
               end
            START:
               if (bit_end) begin
                  state <= deser.sampled_bit ? IDLE : DATA;
                  bit_cnt <= '0;
               end
            DATA: begin
               if (tick) begin
                  deser.deser_en <= 1'b1;
                  par_acc <= par_acc ^ vote;
               end
               if (bit_end) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= par_en_l ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (tick) deser.par_err <= (par_acc ^ vote) != par_typ_l;
               if (bit_end) state <= STOP;
            end
            STOP: begin
               if (tick) begin
                  deser.stp_err <= ~vote;
                  deser.data_valid <= vote & ~deser.par_err;
               end
               // leave half a bit early so a back-to-back start edge is caught
               if (edge_cnt == m + PRESCALE_W'(2)) begin
                  state <= IDLE;
                  edge_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized and directed frame bench for uart_rx_ctrl against a frame-level model.
module tb_uart_rx_ctrl;
   logic clk = 1'b0, rst_n = 1'b0, rx_in = 1'b1, par_en = 1'b0, par_typ = 1'b0;
   logic [5:0] prescale = 6'd8;
   int tests = 0, fails = 0, dv_cnt = 0, total_de = 0, de0;
   bit q[$];
   uart_rx_ctrl_if deser();
   uart_rx_ctrl #(.PRESCALE_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .prescale(prescale),
      .par_en(par_en), .par_typ(par_typ), .deser(deser)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (deser.deser_en) begin
         q.push_back(deser.sampled_bit);
         total_de++;
      end
      if (deser.data_valid) dv_cnt++;
   end
   task automatic check(input string tag, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask
   task automatic send_frame(input int p_in, input logic [7:0] d, input bit pe, input bit pt,
                             input bit flip, input bit stop, input int glitch, input int abort_at,
                             input int idle_after);
      int pw, nb, len;
      logic [10:0] bits;
      logic [7:0] got;
      pw = p_in < 8 ? 8 : p_in;
      nb = pe ? 11 : 10;
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = d;
      if (pe) bits[9] = ^d ^ pt ^ flip;
      bits[nb-1] = stop;
      got = '0;
      prescale = 6'(p_in);
      par_en = pe;
      par_typ = pt;
      q.delete();
      dv_cnt = 0;
      for (int b = 0; b < nb; b++) begin
         // a low stop bit is cut short so the line is high again when the receiver is idle
         len = (b == nb - 1 && !stop) ? pw / 2 + 3 : pw;
         for (int j = 0; j < len; j++) begin
            rx_in = (glitch >= 0 && b == glitch + 1 && j == pw / 2) ? ~bits[b] : bits[b];
            if (b == 0 && j == 1) begin
               prescale = 6'($urandom);
               par_en = 1'($urandom);
               par_typ = 1'($urandom);
            end
            if (b == 0 && j == 2) check("flags_clr", {deser.par_err, deser.stp_err}, 0);
            if (abort_at >= 0 && b == abort_at + 1 && j == 2) begin
               rst_n = 1'b0;
               #1;
               check("abort_outs", {deser.sampled_bit, deser.deser_en, deser.data_valid,
                                    deser.par_err, deser.stp_err}, 0);
               @(negedge clk);
               rst_n = 1'b1;
               rx_in = 1'b1;
               repeat (4) @(negedge clk);
               return;
            end
            @(negedge clk);
         end
      end
      rx_in = 1'b1;
      check("n_deser", q.size(), 8);
      foreach (q[i]) if (i < 8) got[i] = q[i];
      check("data", got, d);
      check("data_valid", dv_cnt, (!(pe && flip) && stop) ? 1 : 0);
      check("par_err", deser.par_err, (pe && flip) ? 1 : 0);
      check("stp_err", deser.stp_err, stop ? 0 : 1);
      repeat (idle_after) @(negedge clk);
   endtask
   initial begin
      int k;
      repeat (3) @(negedge clk);
      check("reset_outs", {deser.sampled_bit, deser.deser_en, deser.data_valid,
                           deser.par_err, deser.stp_err}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      send_frame(8, 8'hA5, 0, 0, 0, 1, -1, -1, 4);
      send_frame(16, 8'h3C, 1, 0, 0, 1, -1, -1, 4);
      send_frame(16, 8'h3C, 1, 0, 1, 1, -1, -1, 4);
      send_frame(8, 8'h96, 0, 0, 0, 0, -1, -1, 4);
      send_frame(8, 8'h69, 0, 0, 0, 1, -1, -1, 4);
      prescale = 6'd16;
      q.delete();
      dv_cnt = 0;
      rx_in = 1'b0;
      repeat (3) @(negedge clk);
      rx_in = 1'b1;
      repeat (48) @(negedge clk);
      check("runt_deser", q.size(), 0);
      check("runt_dv", dv_cnt, 0);
      check("runt_flags", {deser.par_err, deser.stp_err}, 0);
      send_frame(16, 8'h5A, 0, 0, 0, 1, 3, -1, 4);
      send_frame(16, 8'hC3, 1, 1, 0, 1, -1, 4, 0);
      send_frame(16, 8'hC3, 1, 1, 0, 1, -1, -1, 4);
      de0 = total_de;
      send_frame(32, 8'h00, 0, 0, 0, 1, -1, -1, 0);
      send_frame(32, 8'hFF, 0, 0, 0, 1, -1, -1, 4);
      check("b2b_deser", total_de - de0, 16);
      send_frame(5, 8'h81, 1, 1, 0, 1, -1, -1, 4);
      for (int n = 0; n < 24; n++) begin
         k = $urandom_range(0, 3);
         send_frame(k == 3 ? $urandom_range(0, 7) : 8 << k, 8'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) ? $urandom_range(0, 7) : -1, -1, $urandom_range(0, 5));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
